// File: rtl/aes_pkg.sv
// Shared AES arithmetic: GF(2^8) helpers, forward/inverse S-box, Rcon and FSM state type.
// S-boxes are built from the field inverse plus the affine map, so no lookup tables need to be maintained.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_ROUND,
        ST_DONE
    } state_e;

    localparam logic [3:0] LAST_KEY_STEP = 4'd10;
    localparam logic [3:0] FIRST_ROUND   = 4'd9;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 by square-and-multiply; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < 6; i++) y = gmul(gmul(y, y), x);
        return gmul(y, y);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] u;
        u = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(u);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES decryption round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless skip_mix is set (final round). No state, no flow control.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         skip_mix,
    output logic [127:0] state_out
);

    logic [127:0] ark;
    logic [127:0] mixed;
    logic [7:0]   a0, a1, a2, a3;

    // byte index 4*c + r sits at bits [127-8*idx -: 8]; row r is rotated right by r columns
    always_comb begin
        ark = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8])
                    ^ round_key[127 - 8*(4*c + r) -: 8];
            end
        end
    end

    always_comb begin
        mixed = '0;
        a0 = 8'h00;
        a1 = 8'h00;
        a2 = 8'h00;
        a3 = 8'h00;
        for (int c = 0; c < 4; c++) begin
            a0 = ark[127 - 32*c      -: 8];
            a1 = ark[127 - 32*c - 8  -: 8];
            a2 = ark[127 - 32*c - 16 -: 8];
            a3 = ark[127 - 32*c - 24 -: 8];
            mixed[127 - 32*c      -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            mixed[127 - 32*c - 8  -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            mixed[127 - 32*c - 16 -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            mixed[127 - 32*c - 24 -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
    end

    assign state_out = skip_mix ? ark : mixed;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor, one round per cycle: 20 cycles accept->out_valid (10 when the cached rk10 matches).
// Accepts only in IDLE; the result is held in DONE until out_ready, so one block is in flight at a time.
module aes128_decrypt_iter
    import aes_pkg::*;
#(
    parameter int KEY_REUSE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    function automatic logic [31:0] rot_sub(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] ks_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ rot_sub(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // rc is the Rcon that produced k from its predecessor
    function automatic logic [127:0] ks_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ rot_sub(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] data_q, data_d;
    logic [127:0] work_key_q, work_key_d;
    logic [127:0] key_q, key_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_rk_q, cache_rk_d;
    logic         cache_vld_q, cache_vld_d;
    logic [127:0] plaintext_q, plaintext_d;
    logic         out_valid_q, out_valid_d;

    logic         accept;
    logic         cache_hit;
    logic [127:0] rk_next;
    logic [127:0] rk_prev;
    logic [127:0] round_out;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign cache_hit = (KEY_REUSE != 0) && cache_vld_q && (key == cache_key_q);
    assign rk_next   = ks_fwd(work_key_q, rcon(cnt_q));
    assign rk_prev   = ks_inv(work_key_q, rcon(cnt_q + 4'd1));

    aes_inv_round u_inv_round (
        .state_in  (data_q),
        .round_key (rk_prev),
        .skip_mix  (cnt_q == 4'd0),
        .state_out (round_out)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        work_key_d  = work_key_q;
        key_d       = key_q;
        cache_key_d = cache_key_q;
        cache_rk_d  = cache_rk_q;
        cache_vld_d = cache_vld_q;
        plaintext_d = plaintext_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    key_d = key;
                    if (cache_hit) begin
                        data_d     = ciphertext ^ cache_rk_q;
                        work_key_d = cache_rk_q;
                        cnt_d      = FIRST_ROUND;
                        state_d    = ST_ROUND;
                    end else begin
                        data_d     = ciphertext;
                        work_key_d = key;
                        cnt_d      = 4'd1;
                        state_d    = ST_KEYEXP;
                    end
                end
            end
            ST_KEYEXP: begin
                work_key_d = rk_next;
                if (cnt_q == LAST_KEY_STEP) begin
                    if (KEY_REUSE != 0) begin
                        cache_rk_d  = rk_next;
                        cache_key_d = key_q;
                        cache_vld_d = 1'b1;
                    end
                    data_d  = data_q ^ rk_next;
                    cnt_d   = FIRST_ROUND;
                    state_d = ST_ROUND;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ROUND: begin
                data_d     = round_out;
                work_key_d = rk_prev;
                if (cnt_q == 4'd0) begin
                    plaintext_d = round_out;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            data_q      <= '0;
            work_key_q  <= '0;
            key_q       <= '0;
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            cache_vld_q <= 1'b0;
            plaintext_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            work_key_q  <= work_key_d;
            key_q       <= key_d;
            cache_key_q <= cache_key_d;
            cache_rk_q  <= cache_rk_d;
            cache_vld_q <= cache_vld_d;
            plaintext_q <= plaintext_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign plaintext = plaintext_q;

endmodule
